// File: rtl/hazard3_timer_pkg.sv
// Shared definitions for the mtimecmp update scheduler: timer register map, FSM encoding, write steps.
// HAZARD3_TIMER_SCHED_SAFE_SEQ_EN selects the 3-write glitch-free update sequence.
package hazard3_timer_pkg;

  localparam logic [15:0] TIMER_CTRL_ADDR    = 16'h0000;
  localparam logic [15:0] TIMER_MTIME_ADDR   = 16'h0008;
  localparam logic [15:0] TIMER_MTIMEH_ADDR  = 16'h000c;
  localparam logic [15:0] TIMER_CMP0_LO_ADDR = 16'h0010;
  localparam logic [15:0] TIMER_CMP0_HI_ADDR = 16'h0014;
  localparam logic [15:0] TIMER_CMP1_LO_ADDR = 16'h0018;
  localparam logic [15:0] TIMER_CMP1_HI_ADDR = 16'h0020;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_t;

  localparam int STEP_W = 2;

`ifdef HAZARD3_TIMER_SCHED_SAFE_SEQ_EN
  localparam int N_STEPS = 3;
`else
  localparam int N_STEPS = 2;
`endif

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } apb_wr_t;

  function automatic logic [15:0] cmp_addr(input logic hart, input logic hi);
    if (hart) begin
      return hi ? TIMER_CMP1_HI_ADDR : TIMER_CMP1_LO_ADDR;
    end
    return hi ? TIMER_CMP0_HI_ADDR : TIMER_CMP0_LO_ADDR;
  endfunction

  // Address/data of write number `step` when loading `cmp` into `hart`'s mtimecmp.
  function automatic apb_wr_t step_write(input logic hart, input logic [STEP_W-1:0] step,
                                         input logic [63:0] cmp);
    apb_wr_t wr;
`ifdef HAZARD3_TIMER_SCHED_SAFE_SEQ_EN
    // Parking hi at all-ones first keeps the compare value above mtime while lo changes.
    case (step)
      2'd0: begin
        wr.addr = cmp_addr(hart, 1'b1);
        wr.data = 32'hffff_ffff;
      end
      2'd1: begin
        wr.addr = cmp_addr(hart, 1'b0);
        wr.data = cmp[31:0];
      end
      default: begin
        wr.addr = cmp_addr(hart, 1'b1);
        wr.data = cmp[63:32];
      end
    endcase
`else
    if (step == '0) begin
      wr.addr = cmp_addr(hart, 1'b0);
      wr.data = cmp[31:0];
    end else begin
      wr.addr = cmp_addr(hart, 1'b1);
      wr.data = cmp[63:32];
    end
`endif
    return wr;
  endfunction

endpackage

// File: rtl/hazard3_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant to the first request at or after the pointer,
// pointer advances past the winner when its transaction completes.
module hazard3_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_done_valid,
  input  logic [IW-1:0] i_done_idx,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_grant_valid
);

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_cand;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_grant_idx;
  logic          w_found;

  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(N)) begin
        w_cand = w_cand - (IW+1)'(N);
      end
      if (!w_found && i_req[w_cand[IW-1:0]]) begin
        w_found                  = 1'b1;
        w_grant[w_cand[IW-1:0]]  = 1'b1;
        w_grant_idx              = w_cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_done_valid) begin
      r_ptr <= (i_done_idx == IW'(N - 1)) ? '0 : i_done_idx + 1'b1;
    end
  end

  assign o_grant       = w_grant;
  assign o_grant_idx   = w_grant_idx;
  assign o_grant_valid = w_found;

endmodule

// File: rtl/hazard3_timer_cmp_sched.sv
// APB master that loads 64-bit mtimecmp values for up to two requesters, round-robin.
// HAZARD3_TIMER_SCHED_SAFE_SEQ_EN (in hazard3_timer_pkg) selects the 3-write glitch-free sequence.
module hazard3_timer_cmp_sched
  import hazard3_timer_pkg::*;
#(
  parameter int N_HARTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_HARTS-1:0]   req_valid,
  input  logic [64*N_HARTS-1:0] req_cmp,
  output logic [N_HARTS-1:0]   req_ready,
  output logic [N_HARTS-1:0]   done,
  output logic                 done_err,
  output logic                 busy,
  output logic [15:0]          paddr,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [31:0]          pwdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  localparam int HW = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

  // Handshake: a request transfers on a cycle where req_valid[h] && req_ready[h];
  // req_ready is only ever offered to the arbitration winner while idle.
  sched_state_t       r_state;
  logic [HW-1:0]      r_hart;
  logic [63:0]        r_cmp;
  logic [STEP_W-1:0]  r_step;
  logic               r_err;
  logic [15:0]        r_paddr;
  logic [31:0]        r_pwdata;
  logic               r_psel;
  logic               r_penable;
  logic               r_pwrite;
  logic [N_HARTS-1:0] r_done;
  logic               r_done_err;

  logic [N_HARTS-1:0] w_grant;
  logic [HW-1:0]      w_grant_idx;
  logic               w_grant_valid;
  logic               w_hs;
  logic               w_seq_done;
  logic [63:0]        w_req_cmp;
  logic [STEP_W-1:0]  w_step_nxt;
  apb_wr_t            w_first_wr;
  apb_wr_t            w_next_wr;

  hazard3_rr_arbiter #(
    .N  (N_HARTS),
    .IW (HW)
  ) u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (req_valid),
    .i_done_valid  (w_seq_done),
    .i_done_idx    (r_hart),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign w_hs       = w_grant_valid && (r_state == ST_IDLE);
  assign w_seq_done = (r_state == ST_DONE);
  assign w_req_cmp  = req_cmp[64*int'(w_grant_idx) +: 64];
  assign w_step_nxt = r_step + 1'b1;
  assign w_first_wr = step_write(w_grant_idx[0], '0, w_req_cmp);
  assign w_next_wr  = step_write(r_hart[0], w_step_nxt, r_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hart     <= '0;
      r_cmp      <= '0;
      r_step     <= '0;
      r_err      <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_done     <= '0;
      r_done_err <= 1'b0;
    end else begin
      r_done     <= '0;
      r_done_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_hart    <= w_grant_idx;
            r_cmp     <= w_req_cmp;
            r_step    <= '0;
            r_err     <= 1'b0;
            r_paddr   <= w_first_wr.addr;
            r_pwdata  <= w_first_wr.data;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b1;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            r_err <= r_err | pslverr;
            if (r_step == STEP_LAST) begin
              r_psel     <= 1'b0;
              r_penable  <= 1'b0;
              r_pwrite   <= 1'b0;
              r_done_err <= r_err | pslverr;
              for (int h = 0; h < N_HARTS; h++) begin
                r_done[h] <= (HW'(h) == r_hart);
              end
              r_state <= ST_DONE;
            end else begin
              // An errored write does not stop the sequence; the error is only reported.
              r_step    <= w_step_nxt;
              r_paddr   <= w_next_wr.addr;
              r_pwdata  <= w_next_wr.data;
              r_penable <= 1'b0;
              r_state   <= ST_SETUP;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign done      = r_done;
  assign done_err  = r_done_err;
  assign busy      = (r_state != ST_IDLE);
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;

endmodule

// File: tb/tb_hazard3_timer_cmp_sched.sv
// Directed bench for hazard3_timer_cmp_sched: table of single-requester transactions plus
// hand-written arbitration and mid-sequence reset sequences.
module tb_hazard3_timer_cmp_sched;

  localparam int N = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [64*N-1:0] req_cmp;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   done;
  logic           done_err;
  logic           busy;
  logic [15:0]    paddr;
  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [31:0]    pwdata;
  logic           pready;
  logic           pslverr;

  int n_checks;
  int n_err;

  typedef struct packed {
    int               hart;
    logic [63:0]      cmp;
    int               wait_step;
    int               wait_n;
    int               err_step;
    int               exp_n;
    logic [2:0][15:0] ea;
    logic [2:0][31:0] ed;
    int               exp_cyc;
    logic             exp_err;
  } vec_t;

  hazard3_timer_cmp_sched #(.N_HARTS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_cmp   (req_cmp),
    .req_ready (req_ready),
    .done      (done),
    .done_err  (done_err),
    .busy      (busy),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    req_cmp   = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkv(input int hart, input logic [63:0] cmp, input int ws, input int wn,
                               input int es, input int n, input logic [15:0] a0, input logic [15:0] a1,
                               input logic [15:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input int cyc, input logic err);
    vec_t v;
    v.hart = hart; v.cmp = cmp; v.wait_step = ws; v.wait_n = wn; v.err_step = es; v.exp_n = n;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
    v.exp_cyc = cyc; v.exp_err = err;
    return v;
  endfunction

  // Called at the falling edge of an idle cycle with req_valid[v.hart] already driven;
  // plays the APB slave and returns at the falling edge of the idle cycle after done.
  task automatic do_seq(input vec_t v);
    int          cyc;
    int          nw;
    int          waited;
    int          step;
    bit          seen_done;
    logic [15:0] sa;
    logic [31:0] sd;
    logic [15:0] ga [4];
    logic [31:0] gd [4];
    logic [N-1:0] exp_oh;
    exp_oh = '0;
    exp_oh[v.hart] = 1'b1;
    nw = 0; waited = 0; step = 0; seen_done = 1'b0; sa = '0; sd = '0;
    for (int i = 0; i < 4; i++) begin ga[i] = '0; gd[i] = '0; end
    #1;
    chk("req_ready_winner", req_ready, exp_oh);
    @(posedge clk);
    #1;
    req_valid[v.hart] = 1'b0;
    cyc = 1;
    while (!seen_done && cyc <= 40) begin
      @(negedge clk);
      if (done != '0) begin
        seen_done = 1'b1;
        chk("done_onehot", done, exp_oh);
        chk("done_err", done_err, v.exp_err);
        chk("done_cycle", cyc, v.exp_cyc);
        chk("psel_in_done", psel, 1'b0);
        pready  = 1'b0;
        pslverr = 1'b0;
      end else begin
        chk("ready_while_busy", req_ready, '0);
        chk("busy_in_seq", busy, 1'b1);
        if (psel && !penable) begin
          sa = paddr;
          sd = pwdata;
          pready  = 1'b0;
          pslverr = 1'b0;
        end else if (psel && penable) begin
          chk("access_paddr_stable", paddr, sa);
          chk("access_pwdata_stable", pwdata, sd);
          chk("access_pwrite", pwrite, 1'b1);
          if (step == v.wait_step && waited < v.wait_n) begin
            pready  = 1'b0;
            pslverr = 1'b0;
            waited++;
          end else begin
            pready  = 1'b1;
            pslverr = (step == v.err_step);
            if (nw < 4) begin
              ga[nw] = paddr;
              gd[nw] = pwdata;
            end
            nw++;
            step++;
          end
        end else begin
          pready  = 1'b0;
          pslverr = 1'b0;
        end
        @(posedge clk);
        cyc++;
      end
    end
    if (!seen_done) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout: got no done after %0d cycles required done at %0d", cyc, v.exp_cyc);
    end
    chk("write_count", nw, v.exp_n);
    for (int i = 0; i < v.exp_n; i++) begin
      chk($sformatf("write%0d_addr", i), ga[i], v.ea[i]);
      chk($sformatf("write%0d_data", i), gd[i], v.ed[i]);
    end
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse_width", done, '0);
    chk("busy_after_done", busy, 1'b0);
  endtask

  task automatic apply(input vec_t v);
    req_cmp[64*v.hart +: 64] = v.cmp;
    req_valid[v.hart] = 1'b1;
    do_seq(v);
  endtask

  vec_t tbl [5];
  vec_t va, vb, vc, vd, ve;
  logic [15:0] mid_addr;
  logic [31:0] mid_data;

  initial begin
    n_checks  = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_cmp   = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

`ifdef HAZARD3_TIMER_SCHED_SAFE_SEQ_EN
    tbl[0] = mkv(0, 64'h0000_0001_8000_0000, -1, 0, -1, 3, 16'h14, 16'h10, 16'h14,
                 32'hffff_ffff, 32'h8000_0000, 32'h0000_0001, 7, 1'b0);
    tbl[1] = mkv(1, 64'h0000_0002_0000_0010, -1, 0, -1, 3, 16'h20, 16'h18, 16'h20,
                 32'hffff_ffff, 32'h0000_0010, 32'h0000_0002, 7, 1'b0);
    tbl[2] = mkv(0, 64'h1234_5678_9abc_def0, 1, 3, -1, 3, 16'h14, 16'h10, 16'h14,
                 32'hffff_ffff, 32'h9abc_def0, 32'h1234_5678, 10, 1'b0);
    tbl[3] = mkv(1, 64'hffff_ffff_0000_0000, -1, 0, 0, 3, 16'h20, 16'h18, 16'h20,
                 32'hffff_ffff, 32'h0000_0000, 32'hffff_ffff, 7, 1'b1);
    tbl[4] = mkv(0, 64'hdead_beef_cafe_f00d, 0, 2, 1, 3, 16'h14, 16'h10, 16'h14,
                 32'hffff_ffff, 32'hcafe_f00d, 32'hdead_beef, 9, 1'b1);
    va = mkv(0, 64'h0000_0000_1111_2222, -1, 0, -1, 3, 16'h14, 16'h10, 16'h14,
             32'hffff_ffff, 32'h1111_2222, 32'h0000_0000, 7, 1'b0);
    vb = mkv(1, 64'h0000_0005_3333_4444, -1, 0, -1, 3, 16'h20, 16'h18, 16'h20,
             32'hffff_ffff, 32'h3333_4444, 32'h0000_0005, 7, 1'b0);
    vc = mkv(0, 64'h0000_0006_5555_6666, -1, 0, -1, 3, 16'h14, 16'h10, 16'h14,
             32'hffff_ffff, 32'h5555_6666, 32'h0000_0006, 7, 1'b0);
    vd = mkv(0, 64'h0000_0007_7777_8888, -1, 0, -1, 3, 16'h14, 16'h10, 16'h14,
             32'hffff_ffff, 32'h7777_8888, 32'h0000_0007, 7, 1'b0);
    ve = mkv(1, 64'h0000_0003_0000_0004, -1, 0, -1, 3, 16'h20, 16'h18, 16'h20,
             32'hffff_ffff, 32'h0000_0004, 32'h0000_0003, 7, 1'b0);
    mid_addr = 16'h18;
    mid_data = 32'h0000_0004;
`else
    tbl[0] = mkv(0, 64'h0000_0002_0000_0010, -1, 0, -1, 2, 16'h10, 16'h14, 16'h0,
                 32'h0000_0010, 32'h0000_0002, 32'h0, 5, 1'b0);
    tbl[1] = mkv(1, 64'h1234_5678_9abc_def0, -1, 0, -1, 2, 16'h18, 16'h20, 16'h0,
                 32'h9abc_def0, 32'h1234_5678, 32'h0, 5, 1'b0);
    tbl[2] = mkv(0, 64'h0000_0001_8000_0000, 1, 3, -1, 2, 16'h10, 16'h14, 16'h0,
                 32'h8000_0000, 32'h0000_0001, 32'h0, 8, 1'b0);
    tbl[3] = mkv(1, 64'hffff_ffff_0000_0000, -1, 0, 0, 2, 16'h18, 16'h20, 16'h0,
                 32'h0000_0000, 32'hffff_ffff, 32'h0, 5, 1'b1);
    tbl[4] = mkv(0, 64'hdead_beef_cafe_f00d, 0, 2, 1, 2, 16'h10, 16'h14, 16'h0,
                 32'hcafe_f00d, 32'hdead_beef, 32'h0, 7, 1'b1);
    va = mkv(0, 64'h0000_0000_1111_2222, -1, 0, -1, 2, 16'h10, 16'h14, 16'h0,
             32'h1111_2222, 32'h0000_0000, 32'h0, 5, 1'b0);
    vb = mkv(1, 64'h0000_0005_3333_4444, -1, 0, -1, 2, 16'h18, 16'h20, 16'h0,
             32'h3333_4444, 32'h0000_0005, 32'h0, 5, 1'b0);
    vc = mkv(0, 64'h0000_0006_5555_6666, -1, 0, -1, 2, 16'h10, 16'h14, 16'h0,
             32'h5555_6666, 32'h0000_0006, 32'h0, 5, 1'b0);
    vd = mkv(0, 64'h0000_0007_7777_8888, -1, 0, -1, 2, 16'h10, 16'h14, 16'h0,
             32'h7777_8888, 32'h0000_0007, 32'h0, 5, 1'b0);
    ve = mkv(1, 64'h0000_0003_0000_0004, -1, 0, -1, 2, 16'h18, 16'h20, 16'h0,
             32'h0000_0004, 32'h0000_0003, 32'h0, 5, 1'b0);
    mid_addr = 16'h20;
    mid_data = 32'h0000_0003;
`endif

    // reset state
    do_reset();
    #1;
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 16'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_done", done, '0);
    chk("rst_done_err", done_err, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // table of single-requester transactions
    for (int t = 0; t < 5; t++) begin
      apply(tbl[t]);
    end

    // simultaneous requests: hart 0 first after reset, then rotation favours hart 1
    do_reset();
    req_cmp[0 +: 64]  = va.cmp;
    req_cmp[64 +: 64] = vb.cmp;
    req_valid = 2'b11;
    do_seq(va);
    req_cmp[0 +: 64] = vc.cmp;
    req_valid[0] = 1'b1;
    do_seq(vb);
    do_seq(vc);

    // reset during ACCESS of step 1 with the pointer sitting at hart 1
    req_cmp[64 +: 64] = ve.cmp;
    req_valid[1] = 1'b1;
    pready = 1'b1;
    #1;
    chk("mid_req_ready", req_ready, 2'b10);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_in_access", {psel, penable}, 2'b11);
    chk("mid_step1_addr", paddr, mid_addr);
    chk("mid_step1_data", pwdata, mid_data);
    rst_n  = 1'b0;
    pready = 1'b0;
    #1;
    chk("mid_rst_psel", psel, 1'b0);
    chk("mid_rst_penable", penable, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, '0);
    end
    req_cmp[0 +: 64]  = vd.cmp;
    req_cmp[64 +: 64] = ve.cmp;
    req_valid = 2'b11;
    do_seq(vd);
    do_seq(ve);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
